exposure_ctrl: RTL and testbench

EXPOSURE_CTRL -- requirements
Module: exposure_ctrl

---
 rtl/camera_pkg.sv | 35 +++
 rtl/exp_time_reg.sv | 46 ++++
 rtl/exposure_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_exposure_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// -----------------------------------------------------------------------------
// camera_pkg
// Constants shared by the camera exposure controller:
//   - FSM state encoding (IDLE / EXPOSE / READOUT)
//   - READOUT step encoding (r0..r5)
//   - Exp_Time width and default EXP_MIN / EXP_MAX / EXP_RESET values
// No ports (package).
// -----------------------------------------------------------------------------
package camera_pkg;

    localparam int unsigned EXP_W         = 5;
    localparam int unsigned EXP_MIN_DEF   = 2;
    localparam int unsigned EXP_MAX_DEF   = 30;
    localparam int unsigned EXP_RESET_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXPOSE  = 2'd1,
        ST_READOUT = 2'd2
    } state_t;

    // Readout sequence: row 1 select, row 1 convert, row 1 release,
    // then the same three steps for row 2.
    typedef enum logic [2:0] {
        RD_R0 = 3'd0,
        RD_R1 = 3'd1,
        RD_R2 = 3'd2,
        RD_R3 = 3'd3,
        RD_R4 = 3'd4,
        RD_R5 = 3'd5
    } rd_step_t;

    localparam rd_step_t RD_LAST = RD_R5;

endpackage

// File: rtl/exp_time_reg.sv
// -----------------------------------------------------------------------------
// exp_time_reg
// Exposure-time setting register with saturating up/down adjustment.
// Ports:
//   clk    in   clock, posedge
//   reset  in   synchronous active-high reset, loads RST
//   enable in   adjustment allowed this cycle
//   up     in   increment by 1, saturating at MAX
//   down   in   decrement by 1, saturating at MIN
//   value  out  current setting (EXP_W bits)
// up and down together leave the value unchanged.
// -----------------------------------------------------------------------------
module exp_time_reg
    import camera_pkg::*;
#(
    parameter int unsigned MIN = EXP_MIN_DEF,
    parameter int unsigned MAX = EXP_MAX_DEF,
    parameter int unsigned RST = EXP_RESET_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             down,
    output logic [EXP_W-1:0] value
);

    localparam logic [EXP_W-1:0] MIN_V = EXP_W'(MIN);
    localparam logic [EXP_W-1:0] MAX_V = EXP_W'(MAX);
    localparam logic [EXP_W-1:0] RST_V = EXP_W'(RST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= RST_V;
        end else if (enable && (up != down)) begin
            if (up && (value < MAX_V)) begin
                value <= value + 1'b1;
            end else if (down && (value > MIN_V)) begin
                value <= value - 1'b1;
            end
        end
    end

endmodule

// File: rtl/exposure_ctrl.sv
// -----------------------------------------------------------------------------
// exposure_ctrl
// Pixel-array exposure sequencer: IDLE (erase) -> EXPOSE (timer running)
// -> READOUT (fixed 6-step strobe sequence) -> IDLE.
// Ports:
//   Clk           in   clock, posedge
//   Reset         in   synchronous active-high reset
//   Init          in   shutter request level; a rising edge starts exposure
//   Exp_increase  in   exposure-up request (IDLE only)
//   Exp_decrease  in   exposure-down request (IDLE only)
//   Ovf5          in   exposure-done flag from the exposure timer
//   Start         out  run command to the exposure timer
//   Exp_Time[4:0] out  exposure setting to the exposure timer
//   Erase         out  pixel erase
//   Expose        out  pixel expose
//   NRE_1, NRE_2  out  active-low row read enables
//   ADC           out  conversion strobe
//   Err           out  one-cycle exposure-timeout pulse
// Build option: define EXPOSURE_CTRL_TIMEOUT_EN to add an EXPOSE watchdog of
// TIMEOUT_CYC cycles; otherwise Err is tied low and EXPOSE waits for Ovf5.
// -----------------------------------------------------------------------------
module exposure_ctrl
    import camera_pkg::*;
#(
    parameter int unsigned EXP_MIN     = EXP_MIN_DEF,
    parameter int unsigned EXP_MAX     = EXP_MAX_DEF,
    parameter int unsigned EXP_RESET   = EXP_RESET_DEF,
    parameter int unsigned TIMEOUT_CYC = 63
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    input  logic             Ovf5,
    output logic             Start,
    output logic [EXP_W-1:0] Exp_Time,
    output logic             Erase,
    output logic             Expose,
    output logic             NRE_1,
    output logic             NRE_2,
    output logic             ADC,
    output logic             Err
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("exposure_ctrl: TIMEOUT_CYC must be at least 1");
    end

    state_t   state, state_nxt;
    rd_step_t step, step_nxt;
    logic     init_prev;
    logic     init_rise;
    logic     timeout;

    logic start_nxt, erase_nxt, expose_nxt, nre1_nxt, nre2_nxt, adc_nxt;

    // init_prev resets to 1 so a level already high at reset release is not
    // mistaken for a new shutter press.
    assign init_rise = Init & ~init_prev;

    // ---------------------------------------------------------------- watchdog
`ifdef EXPOSURE_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd;

    // wd counts completed EXPOSE cycles; the TIMEOUT_CYC-th one without Ovf5
    // ends the exposure.
    assign timeout = (state == ST_EXPOSE) && !Ovf5 && (wd == WD_LAST);

    always_ff @(posedge Clk) begin
        if (Reset || (state != ST_EXPOSE)) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Err <= 1'b0;
        end else begin
            Err <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign Err     = 1'b0;
`endif

    // ------------------------------------------------------------- exposure time
    // An Init rising edge wins over a same-cycle adjustment request.
    exp_time_reg #(
        .MIN (EXP_MIN),
        .MAX (EXP_MAX),
        .RST (EXP_RESET)
    ) u_exp_time (
        .clk    (Clk),
        .reset  (Reset),
        .enable ((state == ST_IDLE) && !init_rise),
        .up     (Exp_increase),
        .down   (Exp_decrease),
        .value  (Exp_Time)
    );

    // ------------------------------------------------------------ next state
    // Outputs are decoded from the next state and registered, so each output
    // flop holds the value belonging to the state register alongside it.
    // NOTE: every always_comb target gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        step_nxt   = step;
        start_nxt  = 1'b0;
        erase_nxt  = 1'b0;
        expose_nxt = 1'b0;
        nre1_nxt   = 1'b1;
        nre2_nxt   = 1'b1;
        adc_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (init_rise) begin
                    state_nxt = ST_EXPOSE;
                end
            end
            ST_EXPOSE: begin
                if (Ovf5) begin
                    state_nxt = ST_READOUT;
                    step_nxt  = RD_R0;
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READOUT: begin
                if (step == RD_LAST) begin
                    state_nxt = ST_IDLE;
                    step_nxt  = RD_R0;
                end else begin
                    step_nxt = rd_step_t'(step + 3'd1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                step_nxt  = RD_R0;
            end
        endcase

        case (state_nxt)
            ST_EXPOSE: begin
                start_nxt  = 1'b1;
                expose_nxt = 1'b1;
            end
            ST_READOUT: begin
                case (step_nxt)
                    RD_R0: nre1_nxt = 1'b0;
                    RD_R1: begin
                        nre1_nxt = 1'b0;
                        adc_nxt  = 1'b1;
                    end
                    RD_R3: nre2_nxt = 1'b0;
                    RD_R4: begin
                        nre2_nxt = 1'b0;
                        adc_nxt  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: erase_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            step      <= RD_R0;
            init_prev <= 1'b1;
            Start     <= 1'b0;
            Erase     <= 1'b1;
            Expose    <= 1'b0;
            NRE_1     <= 1'b1;
            NRE_2     <= 1'b1;
            ADC       <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            init_prev <= Init;
            Start     <= start_nxt;
            Erase     <= erase_nxt;
            Expose    <= expose_nxt;
            NRE_1     <= nre1_nxt;
            NRE_2     <= nre2_nxt;
            ADC       <= adc_nxt;
        end
    end

endmodule

// File: tb/tb_exposure_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exposure_ctrl
// Self-checking bench for exposure_ctrl: directed scenarios followed by
// randomized stimulus, every cycle compared against a behavioural model.
// Define EXPOSURE_CTRL_TIMEOUT_EN for both bench and RTL to cover the watchdog.
// -----------------------------------------------------------------------------
module tb_exposure_ctrl;

`ifdef EXPOSURE_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int TIMEOUT    = 63;
    localparam int E_MIN      = 2;
    localparam int E_MAX      = 30;
    localparam int E_RST      = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Init = 1'b0;
    logic       Exp_increase = 1'b0;
    logic       Exp_decrease = 1'b0;
    logic       Ovf5 = 1'b0;
    logic       Start, Erase, Expose, NRE_1, NRE_2, ADC, Err;
    logic [4:0] Exp_Time;

    exposure_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Init         (Init),
        .Exp_increase (Exp_increase),
        .Exp_decrease (Exp_decrease),
        .Ovf5         (Ovf5),
        .Start        (Start),
        .Exp_Time     (Exp_Time),
        .Erase        (Erase),
        .Expose       (Expose),
        .NRE_1        (NRE_1),
        .NRE_2        (NRE_2),
        .ADC          (ADC),
        .Err          (Err)
    );

    initial forever #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    // Phase names: 0 = waiting/erasing, 1 = exposing, 2 = reading out.
    int m_phase = 0;
    int m_step  = 0;
    int m_exp   = E_RST;
    bit m_prev  = 1'b1;
    int m_wd    = 0;
    bit m_err   = 1'b0;

    // Readout strobe waveform, one entry per readout cycle.
    bit rd_nre1 [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit rd_nre2 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bit rd_adc  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic model_edge();
        bit rise;
        if (Reset) begin
            m_phase = 0; m_step = 0; m_exp = E_RST; m_prev = 1'b1; m_wd = 0; m_err = 1'b0;
            return;
        end
        rise  = Init && !m_prev;
        m_err = 1'b0;
        case (m_phase)
            0: begin
                if (rise) begin
                    m_phase = 1;
                    m_wd    = 0;
                end else if (Exp_increase && !Exp_decrease) begin
                    m_exp = (m_exp + 1 > E_MAX) ? E_MAX : m_exp + 1;
                end else if (Exp_decrease && !Exp_increase) begin
                    m_exp = (m_exp - 1 < E_MIN) ? E_MIN : m_exp - 1;
                end
            end
            1: begin
                if (Ovf5) begin
                    m_phase = 2;
                    m_step  = 0;
                end else if (TIMEOUT_EN) begin
                    m_wd++;
                    if (m_wd == TIMEOUT) begin
                        m_phase = 0;
                        m_err   = 1'b1;
                    end
                end
            end
            default: begin
                if (m_step == 5) m_phase = 0;
                else             m_step++;
            end
        endcase
        m_prev = Init;
    endtask

    function automatic logic [11:0] model_vec();
        logic st, er, ex, n1, n2, ad;
        st = 1'b0; er = 1'b0; ex = 1'b0; n1 = 1'b1; n2 = 1'b1; ad = 1'b0;
        if (m_phase == 0) er = 1'b1;
        else if (m_phase == 1) begin st = 1'b1; ex = 1'b1; end
        else begin n1 = rd_nre1[m_step]; n2 = rd_nre2[m_step]; ad = rd_adc[m_step]; end
        return {st, er, ex, n1, n2, ad, m_err, 5'(m_exp)};
    endfunction

    // --------------------------------------------------------------- driver
    bit last_expose = 1'b0;
    int exposures   = 0;
    int err_pulses  = 0;

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        check("cycle", {20'd0, Start, Erase, Expose, NRE_1, NRE_2, ADC, Err, Exp_Time},
              {20'd0, model_vec()});
        if (Expose && !last_expose) exposures++;
        last_expose = Expose;
        if (Err) err_pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1; Init = 1'b0; Exp_increase = 1'b0; Exp_decrease = 1'b0; Ovf5 = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        do_reset();
        tick();
        check("reset_exp_time", Exp_Time, E_RST);
        check("reset_erase", Erase, 1);
        check("reset_nre", {NRE_1, NRE_2, ADC, Start, Expose, Err}, 6'b110000);

        // Increase saturates at EXP_MAX.
        Exp_increase = 1'b1;
        ticks(20);
        Exp_increase = 1'b0;
        check("inc_sat", Exp_Time, E_MAX);
        check("inc_erase", Erase, 1);

        // Decrease saturates at EXP_MIN; both buttons hold the value.
        do_reset();
        Exp_decrease = 1'b1;
        ticks(20);
        check("dec_sat", Exp_Time, E_MIN);
        Exp_increase = 1'b1;
        ticks(3);
        check("both_hold", Exp_Time, E_MIN);
        Exp_decrease = 1'b0;
        ticks(2);
        Exp_increase = 1'b0;
        check("inc_from_min", Exp_Time, E_MIN + 2);

        // Full exposure: Init edge, Ovf5 five cycles later, readout, back to idle.
        do_reset();
        tick();
        Init = 1'b1;
        tick();
        check("expose_start", {Start, Expose, Erase}, 3'b110);
        Init = 1'b0;
        ticks(4);
        Ovf5 = 1'b1;
        tick();
        Ovf5 = 1'b0;
        check("r0_nre1", {NRE_1, ADC, Expose}, 3'b000);
        tick();
        check("r1_adc", {NRE_1, ADC}, 2'b01);
        ticks(5);
        check("back_idle", {Erase, NRE_1, NRE_2, ADC, Start}, 5'b11100);

        // Init held high: one exposure only; release and press again: a second.
        exposures = 0;
        Init = 1'b1;
        ticks(3);
        Ovf5 = 1'b1;
        tick();
        Ovf5 = 1'b0;
        ticks(20);
        check("held_one_exposure", exposures, 1);
        Init = 1'b0;
        tick();
        Init = 1'b1;
        ticks(2);
        Ovf5 = 1'b1;
        tick();
        Ovf5 = 1'b0;
        Init = 1'b0;
        ticks(8);
        check("second_exposure", exposures, 2);

        // Adjustment dropped when it coincides with an Init edge.
        Exp_increase = 1'b1;
        Init = 1'b1;
        tick();
        check("adj_dropped", Exp_Time, E_RST);
        Init = 1'b0;
        ticks(3);
        check("adj_ignored_expose", Exp_Time, E_RST);
        Exp_increase = 1'b0;
        Ovf5 = 1'b1;
        tick();
        Ovf5 = 1'b0;
        ticks(7);

        // Reset in the middle of readout step r3.
        Exp_decrease = 1'b1;
        ticks(4);
        Exp_decrease = 1'b0;
        Init = 1'b1;
        tick();
        Init = 1'b0;
        Ovf5 = 1'b1;
        tick();
        Ovf5 = 1'b0;
        ticks(3);
        check("at_r3", {NRE_1, NRE_2}, 2'b10);
        do_reset();
        check("abort_idle", {Erase, NRE_2, ADC, Expose}, 4'b1100);
        check("abort_exp_time", Exp_Time, E_RST);
        ticks(4);
        check("abort_no_strobe", {NRE_1, NRE_2, ADC}, 3'b110);

        // Ovf5 held low: watchdog fires (when built in) or EXPOSE persists.
        err_pulses = 0;
        Init = 1'b1;
        tick();
        Init = 1'b0;
        ticks(TIMEOUT + 17);
        check("timeout_err_pulses", err_pulses, TIMEOUT_EN ? 1 : 0);
        check("timeout_state", Expose, TIMEOUT_EN ? 0 : 1);
        if (!TIMEOUT_EN) begin
            Ovf5 = 1'b1;
            tick();
            Ovf5 = 1'b0;
            ticks(7);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            Reset        = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) Init = ~Init;
            Exp_increase = ($urandom_range(0, 2) == 0);
            Exp_decrease = ($urandom_range(0, 2) == 0);
            Ovf5         = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
